// File: rtl/seq_divider_16.sv
// Sequential restoring divider: signed or unsigned 16-bit operands, one quotient bit per cycle.
// A zero divisor bypasses the iteration loop and returns all-ones with the dividend as remainder.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             alu_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             neg_flag,
    output logic             zero_flag
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] dvd, dvs, prem, quo;
    logic [CW-1:0]    count;
    logic             dz_reg;

    logic             a_neg, b_neg, last_step, fits;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, res_q, res_r;
    logic [WIDTH:0]   trial, diff;

    // Sign and magnitude of the captured operands; magnitudes of 16'h8000 stay 16'h8000.
    assign a_neg = sgn_reg & a_reg[WIDTH-1];
    assign b_neg = sgn_reg & b_reg[WIDTH-1];
    assign a_mag = a_neg ? -a_reg : a_reg;
    assign b_mag = b_neg ? -b_reg : b_reg;

    // The shifted-in partial remainder needs one extra bit; the borrow of the trial
    // subtraction tells whether the divisor fits.
    assign trial     = {prem, dvd[WIDTH-1]};
    assign diff      = trial - {1'b0, dvs};
    assign fits      = ~diff[WIDTH];
    assign last_step = (count == CW'(WIDTH - 1));

    assign q_fix = (a_neg ^ b_neg) ? -quo : quo;
    assign r_fix = a_neg ? -prem : prem;
    assign res_q = dz_reg ? {WIDTH{1'b1}} : q_fix;
    assign res_r = dz_reg ? a_reg : r_fix;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = (b_reg == '0) ? FIX : CALC;
            CALC:    if (last_step) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sgn_reg <= 1'b0;
            dvd     <= '0;
            dvs     <= '0;
            prem    <= '0;
            quo     <= '0;
            count   <= '0;
            dz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        sgn_reg <= alu_signed;
                    end
                end
                PREP: begin
                    dvd    <= a_mag;
                    dvs    <= b_mag;
                    prem   <= '0;
                    quo    <= '0;
                    count  <= '0;
                    dz_reg <= (b_reg == '0);
                end
                CALC: begin
                    prem  <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], fits};
                    dvd   <= {dvd[WIDTH-2:0], 1'b0};
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Results are written only on the edge that enters DONE and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            neg_flag    <= 1'b0;
            zero_flag   <= 1'b0;
        end else if (state == FIX) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= dz_reg;
            neg_flag    <= sgn_reg & res_q[WIDTH-1];
            zero_flag   <= (res_q == '0);
        end
    end

endmodule

// File: tb/tb_seq_divider_16.sv
// Self-checking bench for seq_divider_16: directed vector table, random operations against
// an arithmetic reference, mid-operation reset and start held high across operations.
module tb_seq_divider_16;

    logic        clk, rst_n, start, alu_signed;
    logic [15:0] A, B, quotient, remainder;
    logic        busy, done, div_by_zero, neg_flag, zero_flag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] held_q, held_r;

    seq_divider_16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_signed(alu_signed),
        .A(A), .B(B), .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .neg_flag(neg_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        neg;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        neg;
        logic        zero;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } op_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic (SV '/' and '%' truncate toward zero).
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        res_t res;
        int   sa, sb, qi, ri;
        if (b == 16'd0) begin
            res.q  = 16'hFFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else if (!s) begin
            res.q  = a / b;
            res.r  = a % b;
            res.dz = 1'b0;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            qi = sa / sb;
            ri = sa % sb;
            res.q  = qi[15:0];
            res.r  = ri[15:0];
            res.dz = 1'b0;
        end
        res.neg  = s & res.q[15];
        res.zero = (res.q == 16'd0);
        return res;
    endfunction

    // Starts one operation, returns the number of edges from acceptance to done (or -1).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        @(negedge clk);
        start = 1'b1; A = a; B = b; alu_signed = s;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; alu_signed = ~s;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 5) begin
                check("hold_quotient", 32'(quotient), 32'(held_q));
                check("hold_remainder", 32'(remainder), 32'(held_r));
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 40 cycles (a=%h b=%h s=%0d)", a, b, s);
        end else begin
            check("busy_in_done", 32'(busy), 32'd1);
        end
    endtask

    task automatic check_result(input string tag, input res_t e);
        check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
        check({tag, "_neg_flag"}, 32'(neg_flag), 32'(e.neg));
        check({tag, "_zero_flag"}, 32'(zero_flag), 32'(e.zero));
    endtask

    task automatic after_done(input res_t e);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("result_held", 32'(quotient), 32'(e.q));
        held_q = e.q;
        held_r = e.r;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
        check({tag, "_neg_flag"}, 32'(neg_flag), 32'd0);
        check({tag, "_zero_flag"}, 32'(zero_flag), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        op_t  pend[$];
        op_t  op;
        res_t e;
        int   lat, ignore_edges, n_acc, n_done, n_rst_done;

        clk = 1'b0; rst_n = 1'b0; start = 1'b0; alu_signed = 1'b0; A = '0; B = '0;
        held_q = '0; held_r = '0;

        vecs.push_back('{16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFF9C, 16'd7,     1'b1, 16'hFFF2,  16'hFFFE,  1'b0, 1'b1, 1'b0, 18});
        vecs.push_back('{16'h1234, 16'd0,     1'b0, 16'hFFFF,  16'h1234,  1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{16'h1234, 16'd0,     1'b1, 16'hFFFF,  16'h1234,  1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{16'h8000, 16'hFFFF,  1'b1, 16'h8000,  16'h0000,  1'b0, 1'b1, 1'b0, 18});
        vecs.push_back('{16'h8000, 16'hFFFF,  1'b0, 16'h0000,  16'h8000,  1'b0, 1'b0, 1'b1, 18});
        vecs.push_back('{16'd7,     16'hFFF9,  1'b1, 16'hFFFF,  16'h0000,  1'b0, 1'b1, 1'b0, 18});
        vecs.push_back('{16'hFFFF, 16'hFFFF,  1'b0, 16'd1,     16'd0,     1'b0, 1'b0, 1'b0, 18});
        vecs.push_back('{16'd5,     16'd10,    1'b0, 16'd0,     16'd5,     1'b0, 1'b0, 1'b1, 18});
        vecs.push_back('{16'h8000, 16'd3,     1'b1, 16'hD556,  16'hFFFE,  1'b0, 1'b1, 1'b0, 18});

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            e = '{vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].neg, vecs[i].zero};
            check_result($sformatf("vec%0d", i), e);
            after_done(e);
        end

        for (int i = 0; i < 40; i++) begin
            op.a = 16'($urandom);
            case ($urandom_range(7))
                0:       op.b = 16'd0;
                1:       op.b = 16'($urandom_range(15));
                2:       op.b = 16'hFFFF;
                default: op.b = 16'($urandom);
            endcase
            if ($urandom_range(7) == 0) op.a = 16'h8000;
            op.s = 1'($urandom_range(1));
            e = model(op.a, op.b, op.s);
            run_op(op.a, op.b, op.s, lat);
            check("rand_latency", 32'(lat), (op.b == 16'd0) ? 32'd2 : 32'd18);
            check_result("rand", e);
            after_done(e);
        end

        // Reset in the middle of an operation: outputs clear at once and no done follows.
        run_op(16'd100, 16'd7, 1'b0, lat);
        after_done(model(16'd100, 16'd7, 1'b0));
        @(negedge clk);
        start = 1'b1; A = 16'd5000; B = 16'd3; alu_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        held_q = '0;
        held_r = '0;
        n_rst_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) n_rst_done++;
        end
        check("no_done_after_abort", 32'(n_rst_done), 32'd0);
        run_op(16'd9, 16'd3, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd18);
        check_result("post_reset", model(16'd9, 16'd3, 1'b0));
        after_done(model(16'd9, 16'd3, 1'b0));

        // start held high with operands changing every cycle; only idle edges accept.
        ignore_edges = 0;
        n_acc = 0;
        n_done = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (done) begin
                n_done++;
                if (pend.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL held_start_extra_done: done with no accepted start at %0t", $time);
                end else begin
                    op = pend.pop_front();
                    check_result("held_start", model(op.a, op.b, op.s));
                end
            end
            op.a = 16'($urandom);
            op.b = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
            op.s = 1'($urandom_range(1));
            start = 1'b1; A = op.a; B = op.b; alu_signed = op.s;
            if (ignore_edges == 0) begin
                pend.push_back(op);
                n_acc++;
                ignore_edges = (op.b == 16'd0) ? 3 : 19;
            end else begin
                ignore_edges--;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (done) begin
                n_done++;
                if (pend.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL held_start_extra_done: done with no accepted start at %0t", $time);
                end else begin
                    op = pend.pop_front();
                    check_result("held_start", model(op.a, op.b, op.s));
                end
            end
            @(negedge clk);
        end
        check("held_start_done_count", 32'(n_done), 32'(n_acc));
        check("held_start_busy_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
